// File: rtl/actuator_driver.sv
// Actuator driver: registered valve drives plus a dead-time protected drum motor FSM.
// Optional soft-start PWM ramp on the motor drives is built when MOTOR_SOFTSTART_EN is defined.
module actuator_driver #(
  parameter int DEAD_TIME = 8,
  parameter int RAMP_DIV  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic ctrl_fill,
  input  logic ctrl_release,
  input  logic ctrl_forward,
  input  logic ctrl_reverse,
  output logic valve_in,
  output logic valve_out,
  output logic motor_fwd,
  output logic motor_rev,
  output logic busy,
  output logic fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME - 1);

  generate
    if (DEAD_TIME < 1 || DEAD_TIME > 255 || RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_param_check
      $error("actuator_driver: DEAD_TIME and RAMP_DIV must be in 1..255");
    end
  endgenerate

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] dead_cnt_r;
  logic [7:0] dead_cnt_nxt_s;
  logic       fwd_req_s;
  logic       rev_req_s;
  logic       conflict_s;
  logic       drive_s;

  // A conflicting motor request decays to "no request"
  assign fwd_req_s  = ena & ctrl_forward & ~ctrl_reverse;
  assign rev_req_s  = ena & ctrl_reverse & ~ctrl_forward;
  assign conflict_s = ena & ((ctrl_fill & ctrl_release) | (ctrl_forward & ctrl_reverse));

  // Motor FSM next-state and dead-time counter
  always_comb begin
    state_nxt_s    = state_r;
    dead_cnt_nxt_s = dead_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (fwd_req_s) begin
          state_nxt_s = ST_FWD;
        end else if (rev_req_s) begin
          state_nxt_s = ST_REV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (fwd_req_s) begin
          state_nxt_s = ST_FWD;
        end else begin
          state_nxt_s    = ST_DEAD;
          dead_cnt_nxt_s = DEAD_LOAD;
        end
      end
      ST_REV: begin
        if (rev_req_s) begin
          state_nxt_s = ST_REV;
        end else begin
          state_nxt_s    = ST_DEAD;
          dead_cnt_nxt_s = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_r == 8'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          dead_cnt_nxt_s = dead_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        dead_cnt_nxt_s = 8'd0;
      end
    endcase
  end

`ifdef MOTOR_SOFTSTART_EN
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);

  logic [3:0] pwm_cnt_r;
  logic [3:0] pwm_nxt_s;
  logic [3:0] duty_r;
  logic [3:0] duty_nxt_s;
  logic [7:0] ramp_cnt_r;
  logic [7:0] ramp_nxt_s;

  // Duty ramp: restart at 4 on entry to a run state, step every RAMP_DIV cycles, saturate at 15
  always_comb begin
    pwm_nxt_s  = pwm_cnt_r + 4'd1;
    duty_nxt_s = 4'd0;
    ramp_nxt_s = 8'd0;
    if (state_nxt_s == ST_FWD || state_nxt_s == ST_REV) begin
      if (state_r != state_nxt_s) begin
        duty_nxt_s = 4'd4;
        ramp_nxt_s = 8'd0;
      end else if (ramp_cnt_r == RAMP_LAST) begin
        duty_nxt_s = (duty_r == 4'd15) ? 4'd15 : duty_r + 4'd1;
        ramp_nxt_s = 8'd0;
      end else begin
        duty_nxt_s = duty_r;
        ramp_nxt_s = ramp_cnt_r + 8'd1;
      end
    end else begin
      duty_nxt_s = 4'd0;
      ramp_nxt_s = 8'd0;
    end
    drive_s = (duty_nxt_s == 4'd15) || (pwm_nxt_s < duty_nxt_s);
  end

  // PWM and ramp state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r  <= 4'd0;
      duty_r     <= 4'd0;
      ramp_cnt_r <= 8'd0;
    end else begin
      pwm_cnt_r  <= pwm_nxt_s;
      duty_r     <= duty_nxt_s;
      ramp_cnt_r <= ramp_nxt_s;
    end
  end
`else
  assign drive_s = 1'b1;
`endif

  // State and registered outputs; motor/busy decode the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      dead_cnt_r <= 8'd0;
      valve_in   <= 1'b0;
      valve_out  <= 1'b0;
      motor_fwd  <= 1'b0;
      motor_rev  <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dead_cnt_r <= dead_cnt_nxt_s;
      valve_in   <= ena & ctrl_fill & ~ctrl_release;
      valve_out  <= ena & ctrl_release & ~ctrl_fill;
      motor_fwd  <= (state_nxt_s == ST_FWD) & drive_s;
      motor_rev  <= (state_nxt_s == ST_REV) & drive_s;
      busy       <= (state_nxt_s == ST_DEAD);
      fault      <= fault | conflict_s;
    end
  end

endmodule

// File: tb/tb_actuator_driver.sv
// Self-checking bench for actuator_driver: reference model feeds a scoreboard queue,
// plus directed checks for dead time, fault stickiness, enable drop and reset.
module tb_actuator_driver;

  logic clk = 1'b0;
  logic rst, ena, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
  logic valve_in, valve_out, motor_fwd, motor_rev, busy, fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] exp_q[$];
  int         m_state = 0;
  int         m_cnt   = 0;
  bit         m_fault = 1'b0;

`ifdef MOTOR_SOFTSTART_EN
  localparam logic [5:0] CMP_MASK = 6'b110011;
`else
  localparam logic [5:0] CMP_MASK = 6'b111111;
`endif

  actuator_driver #(.DEAD_TIME(8), .RAMP_DIV(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release),
    .ctrl_forward(ctrl_forward), .ctrl_reverse(ctrl_reverse),
    .valve_in(valve_in), .valve_out(valve_out),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns expected {valve_in,valve_out,motor_fwd,motor_rev,busy,fault} after the edge
  task automatic model(input bit r, e, fi, re, fw, rv, output logic [5:0] exp_v);
    bit fq, rq;
    if (r) begin
      m_state = 0; m_cnt = 0; m_fault = 1'b0;
      exp_v = 6'b000000;
    end else begin
      if (e && ((fi && re) || (fw && rv))) m_fault = 1'b1;
      fq = e && fw && !rv;
      rq = e && rv && !fw;
      case (m_state)
        0: if (fq) m_state = 1; else if (rq) m_state = 2;
        1: if (!fq) begin m_state = 3; m_cnt = 7; end
        2: if (!rq) begin m_state = 3; m_cnt = 7; end
        default: if (m_cnt == 0) m_state = 0; else m_cnt--;
      endcase
      exp_v = {e && fi && !re, e && re && !fi, m_state == 1, m_state == 2, m_state == 3, m_fault};
    end
  endtask

  task automatic step(input bit r, e, fi, re, fw, rv);
    logic [5:0] exp_v, got_v;
    rst = r; ena = e; ctrl_fill = fi; ctrl_release = re; ctrl_forward = fw; ctrl_reverse = rv;
    model(r, e, fi, re, fw, rv, exp_v);
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    got_v = {valve_in, valve_out, motor_fwd, motor_rev, busy, fault};
    exp_v = exp_q.pop_front();
    check_eq("scoreboard", 32'(got_v & CMP_MASK), 32'(exp_v & CMP_MASK));
  endtask

  initial begin
    int dead_seen, idle_seen, hits;
    bit rev_seen, done;
    rst = 1'b1; ena = 1'b0; ctrl_fill = 1'b0; ctrl_release = 1'b0;
    ctrl_forward = 1'b0; ctrl_reverse = 1'b0;
    #1;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    check_eq("reset_outputs", 32'({valve_in, valve_out, motor_fwd, motor_rev, busy, fault}), 32'd0);

`ifndef MOTOR_SOFTSTART_EN
    // Forward start and hold
    step(0, 1, 0, 0, 1, 0);
    check_eq("fwd_start", 32'({motor_fwd, motor_rev, busy}), 32'b100);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0);
    check_eq("fwd_hold", 32'(motor_fwd), 32'd1);

    // Reversal passes through exactly 8 dead cycles, one idle cycle, then REV
    dead_seen = 0; idle_seen = 0; rev_seen = 1'b0;
    for (int i = 0; i < 20 && !rev_seen; i++) begin
      step(0, 1, 0, 0, 0, 1);
      if (motor_rev) rev_seen = 1'b1;
      else if (busy && !motor_fwd) dead_seen++;
      else if (!busy && !motor_fwd) idle_seen++;
    end
    check_eq("rev_reached", 32'(rev_seen), 32'd1);
    check_eq("rev_dead_cycles", 32'(dead_seen), 32'd8);
    check_eq("rev_idle_cycles", 32'(idle_seen), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);

    // Valves, then conflicting valve request sets sticky fault
    step(0, 1, 1, 0, 0, 0);
    check_eq("fill_only", 32'({valve_in, valve_out}), 32'b10);
    step(0, 1, 0, 1, 0, 0);
    check_eq("release_only", 32'({valve_in, valve_out}), 32'b01);
    step(0, 1, 1, 1, 0, 0);
    check_eq("valve_conflict", 32'({valve_in, valve_out, fault}), 32'b001);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    check_eq("fault_sticky", 32'(fault), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    check_eq("fault_cleared", 32'(fault), 32'd0);

    // Conflicting motor request in IDLE: stays idle, faults
    step(0, 1, 0, 0, 1, 1);
    check_eq("motor_conflict", 32'({motor_fwd, motor_rev, busy, fault}), 32'b0001);
    step(1, 0, 0, 0, 0, 0);

    // ena low in IDLE keeps IDLE
    step(0, 0, 1, 0, 1, 0);
    check_eq("ena_low_idle", 32'({valve_in, motor_fwd, busy}), 32'b000);

    // FWD running, drop ena: valves close, 8 dead cycles, then re-run
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    check_eq("ena_drop_valve", 32'({valve_in, motor_fwd, busy}), 32'b001);
    dead_seen = 1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(0, 0, 1, 0, 1, 0);
      if (busy) dead_seen++; else done = 1'b1;
    end
    check_eq("ena_drop_dead", 32'(dead_seen), 32'd8);
    step(0, 1, 0, 0, 1, 0);
    check_eq("ena_restore_fwd", 32'(motor_fwd), 32'd1);

    // Reset mid-FWD: straight to IDLE, no busy pulse
    step(0, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    check_eq("rst_mid_fwd", 32'({valve_in, valve_out, motor_fwd, motor_rev, busy, fault}), 32'd0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (busy) hits++;
    end
    check_eq("rst_no_busy", 32'(hits), 32'd0);
`else
    // Soft start: 4/16 duty on entry, solid after 11*RAMP_DIV cycles
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 1, 0);
      if (motor_fwd) hits++;
    end
    check_eq("soft_initial_duty", 32'(hits), 32'd4);
    for (int i = 0; i < 170; i++) step(0, 1, 0, 0, 1, 0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 1, 0);
      if (motor_fwd) hits++;
      check_eq("soft_no_rev", 32'(motor_rev), 32'd0);
    end
    check_eq("soft_full_duty", 32'(hits), 32'd16);
    step(1, 0, 0, 0, 0, 0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/actuator_driver.md
ACTUATOR_DRIVER -- requirements
Module: actuator_driver

Interface
REQ-001 SHALL have parameter DEAD_TIME, default 8: number of cycles both motor outputs are held low between motor runs (range 1..255).
REQ-002 SHALL have parameter RAMP_DIV, default 16: cycles per soft-start duty step (range 1..255; used only with MOTOR_SOFTSTART_EN).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port ena, input, 1 bit: driver enable; low forces a safe state.
REQ-006 SHALL have ports ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, inputs, 1 bit each: level requests from the washing-program processor.
REQ-007 SHALL have ports valve_in and valve_out, outputs, 1 bit each: inlet and drain valve drives.
REQ-008 SHALL have ports motor_fwd and motor_rev, outputs, 1 bit each: drum motor drives.
REQ-009 SHALL have port busy, output, 1 bit: high while in dead time.
REQ-010 SHALL have port fault, output, 1 bit: sticky conflicting-request flag.

Function
REQ-011 All outputs SHALL be registered, with 1-cycle latency from the sampling edge to the output.
REQ-012 valve_in SHALL equal the registered value of ena & ctrl_fill & ~ctrl_release.
REQ-013 valve_out SHALL equal the registered value of ena & ctrl_release & ~ctrl_fill.
REQ-014 The motor FSM SHALL have exactly four states: IDLE, FWD, REV, DEAD.
REQ-015 From IDLE, with ena high, forward-only SHALL go to FWD, reverse-only SHALL go to REV, and any other input SHALL stay in IDLE.
REQ-016 FWD SHALL stay in FWD while ena is high and the request is forward-only; any other input SHALL go to DEAD with the dead counter loaded to DEAD_TIME-1.
REQ-017 REV SHALL behave like FWD with forward and reverse swapped.
REQ-018 DEAD SHALL decrement the counter each cycle, go to IDLE when the counter reaches 0, and ignore all requests while in DEAD, so every run-to-run transition passes through exactly DEAD_TIME low cycles before IDLE.
REQ-019 motor_fwd SHALL be high only in FWD, and motor_rev only in REV; motor_fwd and motor_rev SHALL never both be high.
REQ-020 busy SHALL be high exactly while in DEAD.
REQ-021 fault SHALL be set on any edge where ena is high and either (ctrl_fill & ctrl_release) or (ctrl_forward & ctrl_reverse) is high.
REQ-022 fault SHALL be cleared only by rst.
REQ-023 A conflicting motor request SHALL be treated as "no request" by the FSM, and a conflicting valve request SHALL close both valves.
REQ-024 Dropping ena SHALL close both valves on the next cycle, send FWD/REV to DEAD, let DEAD complete normally, and keep IDLE in IDLE.

Reset
REQ-025 When rst is sampled high, the FSM SHALL go to IDLE, the dead counter to 0, and valve_in, valve_out, motor_fwd, motor_rev, busy and fault all to 0 on the next cycle.
REQ-026 rst SHALL override ena and all requests.
REQ-027 Reset during FWD/REV SHALL go directly to IDLE with no dead time.

Configuration
REQ-028 With macro MOTOR_SOFTSTART_EN defined, a 4-bit PWM counter SHALL free-run from 0 after reset, wrapping 15->0.
REQ-029 With MOTOR_SOFTSTART_EN defined, a 4-bit duty register SHALL be loaded to 4 on entry to FWD/REV and SHALL increment by 1 every RAMP_DIV cycles in that state, saturating at 15.
REQ-030 With MOTOR_SOFTSTART_EN defined, the active motor output SHALL be high when pwm_cnt < duty, or always when duty = 15; the inactive output SHALL stay 0.
REQ-031 Without MOTOR_SOFTSTART_EN, no PWM or duty logic SHALL exist, and motor outputs SHALL be solid high in FWD/REV.

Verification
REQ-032 Bench SHALL cover: IDLE, ctrl_forward=1 at edge 0 -> motor_fwd=1 after edge 0, held while the request is held, busy=0.
REQ-033 Bench SHALL cover: in FWD, switch to ctrl_reverse=1 -> exactly 8 cycles with both motor outputs 0 and busy=1, then IDLE, then motor_rev=1 on the following cycle.
REQ-034 Bench SHALL cover: ctrl_fill=ctrl_release=1 -> valve_in=valve_out=0 and fault=1; fault stays 1 after both are dropped, until rst.
REQ-035 Bench SHALL cover: FWD running, ena=0 -> valves 0 next cycle, 8-cycle DEAD, IDLE; re-raise ena with ctrl_forward=1 -> FWD.
REQ-036 Bench SHALL cover: rst=1 mid-FWD -> all outputs 0 next cycle, state IDLE, no busy pulse.
REQ-037 With MOTOR_SOFTSTART_EN, bench SHALL cover: enter FWD -> motor_fwd high for 4 of every 16 cycles initially, rising to solid high after 11*RAMP_DIV = 176 cycles.
